// File: rtl/raster_coord_tagger.sv
// Raster coordinate tagger: stamps each accepted pixel with its column/row
// position, tracks frame boundaries on sof and counts beats dropped outside a frame.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// WAIT_SOF | no frame in progress; non-sof beats are dropped and counted
// ACTIVE   | inside a frame; beats are tagged from col_cnt/row_cnt
module raster_coord_tagger #(
  parameter int DATA_WIDTH   = 0,
  parameter int IMAGE_WIDTH  = 0,
  parameter int IMAGE_HEIGHT = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  sof_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [15:0]           col_o,
  output logic [15:0]           row_o,
  output logic                  valid_o,
  output logic                  frame_done_o,
  output logic                  resync_o,
  output logic [15:0]           drop_count_o
);

  typedef enum logic {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);
  localparam bit          SINGLE   = (IMAGE_WIDTH == 1) && (IMAGE_HEIGHT == 1);
  // Position that follows the sof pixel (0,0); a one-column image wraps straight to row 1.
  localparam logic [15:0] SOF_COL_NXT = (IMAGE_WIDTH == 1) ? 16'd0 : 16'd1;
  localparam logic [15:0] SOF_ROW_NXT = ((IMAGE_WIDTH == 1) && !SINGLE) ? 16'd1 : 16'd0;

  state_t      state, state_nxt;
  logic [15:0] col_cnt, row_cnt, col_nxt, row_nxt;
  logic [15:0] emit_col, emit_row, drop_nxt;
  logic        emit, done_nxt, resync_nxt;
  logic        at_eol, at_last;

  assign at_eol  = (col_cnt == LAST_COL);
  assign at_last = at_eol && (row_cnt == LAST_ROW);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= WAIT_SOF;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SOF: if (valid_i && sof_i && !SINGLE) state_nxt = ACTIVE;
      ACTIVE:   if (valid_i && !sof_i && at_last) state_nxt = WAIT_SOF;
      default:  state_nxt = WAIT_SOF;
    endcase
  end

  always_comb begin
    emit       = 1'b0;
    emit_col   = col_cnt;
    emit_row   = row_cnt;
    done_nxt   = 1'b0;
    resync_nxt = 1'b0;
    col_nxt    = col_cnt;
    row_nxt    = row_cnt;
    drop_nxt   = drop_count_o;
    if (valid_i) begin
      if (sof_i) begin
        emit       = 1'b1;
        emit_col   = 16'd0;
        emit_row   = 16'd0;
        done_nxt   = SINGLE;
        resync_nxt = (state == ACTIVE);
        col_nxt    = SOF_COL_NXT;
        row_nxt    = SOF_ROW_NXT;
      end else if (state == ACTIVE) begin
        emit = 1'b1;
        if (at_last) begin
          done_nxt = 1'b1;
          col_nxt  = 16'd0;
          row_nxt  = 16'd0;
        end else if (at_eol) begin
          col_nxt = 16'd0;
          row_nxt = row_cnt + 16'd1;
        end else begin
          col_nxt = col_cnt + 16'd1;
        end
      end else if (drop_count_o != 16'hFFFF) begin
        drop_nxt = drop_count_o + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      data_o       <= '0;
      col_o        <= '0;
      row_o        <= '0;
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
      resync_o     <= 1'b0;
      drop_count_o <= '0;
    end else begin
      col_cnt      <= col_nxt;
      row_cnt      <= row_nxt;
      valid_o      <= emit;
      frame_done_o <= done_nxt;
      resync_o     <= resync_nxt;
      drop_count_o <= drop_nxt;
      if (emit) begin
        data_o <= data_i;
        col_o  <= emit_col;
        row_o  <= emit_row;
      end
    end
  end

endmodule

// File: tb/tb_raster_coord_tagger.sv
// Bench for raster_coord_tagger: a pixel-index frame model checked against the
// DUT every cycle, plus literal expectations for the directed scenarios.
module tb_raster_coord_tagger;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          sof_i = 1'b0;
  logic [DW-1:0] data_o;
  logic [15:0]   col_o, row_o, drop_count_o;
  logic          valid_o, frame_done_o, resync_o;

  int errors = 0;
  int checks = 0;

  raster_coord_tagger #(.DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i), .valid_i(valid_i), .sof_i(sof_i),
    .data_o(data_o), .col_o(col_o), .row_o(row_o), .valid_o(valid_o),
    .frame_done_o(frame_done_o), .resync_o(resync_o), .drop_count_o(drop_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a frame is a sequence of pixel indices 0..N-1; coordinates are idx%W, idx/W.
  bit m_in_frame = 0;
  int m_idx = 0;
  int m_data = 0, m_col = 0, m_row = 0, m_drop = 0;
  bit m_valid = 0, m_done = 0, m_resync = 0;
  int n_emit = 0, n_done = 0, n_resync = 0;

  task automatic m_emit(input int d, input int idx);
    m_valid = 1;
    m_data  = d;
    m_col   = idx % W;
    m_row   = idx / W;
    n_emit++;
  endtask

  always @(posedge clk_i) begin
    m_valid = 0; m_done = 0; m_resync = 0;
    if (!rst_n_i) begin
      m_in_frame = 0; m_idx = 0;
      m_data = 0; m_col = 0; m_row = 0; m_drop = 0;
    end else if (valid_i) begin
      if (sof_i) begin
        m_emit(int'(data_i), 0);
        m_resync = m_in_frame;
        m_idx = 1;
        m_in_frame = 1;
      end else if (m_in_frame) begin
        m_emit(int'(data_i), m_idx);
        m_idx++;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
      if (m_in_frame && m_idx == N) begin
        m_done = 1; m_in_frame = 0; m_idx = 0;
      end
      if (m_done) n_done++;
      if (m_resync) n_resync++;
    end
    #1;
    check("valid_o", int'(valid_o), int'(m_valid));
    check("frame_done_o", int'(frame_done_o), int'(m_done));
    check("resync_o", int'(resync_o), int'(m_resync));
    check("data_o", int'(data_o), m_data);
    check("col_o", int'(col_o), m_col);
    check("row_o", int'(row_o), m_row);
    check("drop_count_o", int'(drop_count_o), m_drop);
  end

  task automatic beat(input bit s, input int d);
    @(negedge clk_i);
    valid_i = 1'b1; sof_i = s; data_i = DW'(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      valid_i = 1'b0; sof_i = 1'b0; data_i = DW'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    valid_i = 1'b0; sof_i = 1'b0;
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  int e0, d0, r0;

  initial begin
    repeat (2) @(negedge clk_i);
    check("reset valid_o", int'(valid_o), 0);
    check("reset drop_count_o", int'(drop_count_o), 0);
    rst_n_i = 1'b1;

    // Single frame, data 0..11.
    e0 = n_emit; d0 = n_done;
    for (int i = 0; i < N; i++) beat(i == 0, i);
    idle(2);
    check("t1 emitted", n_emit - e0, 12);
    check("t1 frame_done count", n_done - d0, 1);
    check("t1 held data", int'(data_o), 11);
    check("t1 held col", int'(col_o), 3);
    check("t1 held row", int'(row_o), 2);

    // Three beats before sof are dropped.
    do_reset();
    e0 = n_emit;
    for (int i = 0; i < 3; i++) beat(1'b0, 50 + i);
    idle(1);
    check("t2 drop_count", int'(drop_count_o), 3);
    check("t2 no emit before sof", n_emit - e0, 0);
    for (int i = 0; i < N; i++) beat(i == 0, 20 + i);
    idle(2);
    check("t2 emitted", n_emit - e0, 12);
    check("t2 drop_count after frame", int'(drop_count_o), 3);

    // Resync: sof lands on frame position 6.
    e0 = n_emit; d0 = n_done; r0 = n_resync;
    for (int i = 0; i < 6; i++) beat(i == 0, i);
    beat(1'b1, 100);
    @(posedge clk_i); #2;
    check("t3 resync_o", int'(resync_o), 1);
    check("t3 resync col", int'(col_o), 0);
    check("t3 resync row", int'(row_o), 0);
    for (int i = 1; i < N; i++) beat(1'b0, 100 + i);
    idle(2);
    check("t3 resync count", n_resync - r0, 1);
    check("t3 frame_done count", n_done - d0, 1);
    check("t3 end col", int'(col_o), 3);
    check("t3 end row", int'(row_o), 2);
    check("t3 end data", int'(data_o), 111);

    // Two frames with random gaps, then back-to-back frames without gaps.
    do_reset();
    e0 = n_emit; d0 = n_done;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) idle(1);
        beat(i == 0, 16 * f + i);
      end
    idle(2);
    check("t4 emitted", n_emit - e0, 24);
    check("t4 frame_done count", n_done - d0, 2);
    check("t4 drop_count", int'(drop_count_o), 0);
    e0 = n_emit; d0 = n_done;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < N; i++) beat(i == 0, 200 + i);
    idle(2);
    check("t4 b2b emitted", n_emit - e0, 24);
    check("t4 b2b frame_done count", n_done - d0, 2);

    // Reset mid-frame.
    for (int i = 0; i < 5; i++) beat(i == 0, 60 + i);
    idle(1);
    @(posedge clk_i); #3;
    rst_n_i = 1'b0;
    #1;
    check("t5 async valid_o", int'(valid_o), 0);
    check("t5 async data_o", int'(data_o), 0);
    check("t5 async col_o", int'(col_o), 0);
    check("t5 async row_o", int'(row_o), 0);
    check("t5 async drop_count_o", int'(drop_count_o), 0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    beat(1'b0, 70); beat(1'b0, 71);
    idle(1);
    check("t5 drop after reset", int'(drop_count_o), 2);
    beat(1'b1, 80);
    @(posedge clk_i); #2;
    check("t5 restart col", int'(col_o), 0);
    check("t5 restart resync", int'(resync_o), 0);
    idle(2);

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 65537; i++) beat(1'b0, i);
    idle(1);
    check("t6 saturated", int'(drop_count_o), 16'hFFFF);
    for (int i = 0; i < 3; i++) beat(1'b0, i);
    idle(2);
    check("t6 saturated hold", int'(drop_count_o), 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
